dac_segment_decoder: RTL and testbench
======================================

# dac_segment_decoder

Digital front end for the segmented current-steering DAC. It accepts an 11-bit code through a valid/ready handshake and splits it into 17 thermometer-cell enables (64 LSB each) and 6 binary-cell enables (32..1 LSB). It can substitute the redundant LSB cell for the primary LSB cell. It sequences power-up and power-down of the current source units (`pdb`, settle wait, enables released before power-down) and registers the analog-testbus select.

## Interface
- `SETTLE_CYC`, default 16: cycles between `pdb` rising and first code acceptance; legal range 1..65535.
- `CODE_MAX`, default 1151: full-scale code, equal to 17*64 + 63; not to be overridden.

- `clk` in 1: clock.
- `rstb` in 1: reset, asynchronous, active-low.
- `en` in 1: DAC enable request.
- `code` in 11: DAC input code, unsigned.
- `code_valid` in 1: `code` is valid.
- `code_ready` out 1: decoder can accept a code.
- `sub_lsb` in 1: 1 routes LSB weight to the redundant cell.
- `atb_sel` in 2: testbus select request.
- `pdb` out 1: power-down negate to the current source units.
- `therm_en` out 17: thermometer cell enables; bit i drives cell i.
- `bin_en` out 6: binary cell enables; bit k has weight 2^k LSB.
- `bin_red_en` out 1: redundant LSB cell enable.
- `atb_ena` out 2: testbus select to the current source units.
- `active` out 1: high in ACTIVE state.
- `sat` out 1: one-cycle pulse, accepted code exceeded `CODE_MAX`.

## Operation
- FSM states are OFF, SETTLE, ACTIVE and SHUTDOWN.
- OFF: `pdb`=0, all enables 0. When `en`=1, go to SETTLE; `pdb`=1 from the next cycle, and the settle counter loads `SETTLE_CYC`-1.
- SETTLE: `pdb`=1, enables 0. The counter decrements each cycle. At 0, go to ACTIVE.
- ACTIVE: `code_ready` = `en` (combinational). A transfer occurs when `code_valid` && `code_ready`.
- On a transfer:
  - Clamp the code as c = min(`code`, `CODE_MAX`); `sat` pulses if `code` > `CODE_MAX`.
  - n = c[10:6] (0..17).
  - `bin_en` <= c[5:0].
  - If `sub_lsb`=1: `bin_red_en` <= c[0] and `bin_en[0]` <= 0. Otherwise `bin_red_en` <= 0.
  - `therm_en` <= n ones placed per the thermometer mapping; see Configuration.
- ACTIVE, no transfer: all enables hold.
- `en`=0 in ACTIVE or SETTLE: go to SHUTDOWN and clear all enables on the same edge. SHUTDOWN lasts 1 cycle with `pdb`=1, then OFF with `pdb`=0. Enables therefore reach 0 at least one cycle before `pdb` falls.
- `en`=1 during SHUTDOWN: ignored; go to OFF, then restart from OFF.
- `en`=0 has priority over a simultaneous `code_valid`. `code_ready` is 0, so no transfer occurs.
- `atb_ena` <= `atb_sel` every cycle in SETTLE/ACTIVE. It is forced to 2'b00 in OFF/SHUTDOWN.
- `sub_lsb` is sampled only at transfer; changing it does not alter held enables.

## Timing
- Reset values: `pdb`=0, `therm_en`=0, `bin_en`=0, `bin_red_en`=0, `atb_ena`=0, `active`=0, `sat`=0, state OFF, rotation pointer 0.
- `code_ready`=0 during reset.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous), including `pdb`=0 with enables 0.
- `en` sampled high at edge t: `pdb`=1 after t. The first transfer is possible at edge t+1+`SETTLE_CYC`.
- Transfer at edge t: `therm_en`/`bin_en`/`bin_red_en`/`sat` valid after t (latency 1). Back-to-back transfers run every cycle.
- All outputs are registered except `code_ready`.

## Configuration
- `DAC_DWA_EN` defined: data-weighted averaging.
  - 5-bit pointer p (0..16).
  - A transfer enables cells p, p+1, …, p+n-1, modulo 17.
  - p <= (p+n) mod 17.
  - n=0 enables nothing and leaves p unchanged; n=17 enables all cells and leaves p unchanged.
  - p resets to 0 on `rstb` and on entry to OFF.
- Not defined: fixed mapping. `therm_en` = cells 0..n-1 set; no pointer logic.

## Test plan
- Power-up, `SETTLE_CYC`=16: raise `en` at edge 0 -> `pdb`=1 after edge 0; `code_ready`=0 through edge 16; `code_ready`=1 and `active`=1 from edge 17.
- Fixed mapping, `code`=1151 -> `therm_en`=17'h1FFFF, `bin_en`=6'h3F. Then `code`=2047 -> same enables and `sat`=1 for one cycle. Then `code`=64 -> `therm_en`=17'h00001, `bin_en`=0.
- `sub_lsb`=1, `code`=5 -> `bin_en`=6'b000100, `bin_red_en`=1, `therm_en`=0.
- `DAC_DWA_EN`, codes 640, 640, 640 (n=10 each) -> `therm_en` = cells 0-9, then 10-16 plus 0-2, then 3-12; pointer ends at 13.
- Power-down: in ACTIVE with `code`=1000 held, drop `en` while `code_valid`=1 -> no transfer; enables 0 after that edge; `pdb`=1 one more cycle, then 0; `atb_ena`=0.
- Reset mid-SETTLE, and `rstb` pulse in ACTIVE -> all outputs 0 immediately; pointer back to 0.

Source files
------------

// File: rtl/dac_segment_decoder.sv
// Segmented current-steering DAC front end: code split, LSB cell substitution and power sequencing.
// Define DAC_DWA_EN to rotate the thermometer cells (data-weighted averaging) instead of a fixed mapping.
module dac_segment_decoder #(
    parameter int SETTLE_CYC = 16,
    parameter int CODE_MAX   = 1151
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        en,
    input  logic [10:0] code,
    input  logic        code_valid,
    output logic        code_ready,
    input  logic        sub_lsb,
    input  logic [1:0]  atb_sel,
    output logic        pdb,
    output logic [16:0] therm_en,
    output logic [5:0]  bin_en,
    output logic        bin_red_en,
    output logic [1:0]  atb_ena,
    output logic        active,
    output logic        sat
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_ACTIVE,
        ST_SHUTDOWN
    } state_t;

    localparam logic [10:0] CODE_MAX_C  = 11'(CODE_MAX);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

    state_t      state;
    logic [15:0] settle_cnt;

    logic        over;
    logic [10:0] clamped;
    logic [4:0]  n_cells;
    logic [5:0]  bin_next;
    logic        red_next;
    logic [16:0] fixed_mask;
    logic [16:0] therm_next;

    assign code_ready = (state == ST_ACTIVE) && en;

    assign over       = code > CODE_MAX_C;
    assign clamped    = over ? CODE_MAX_C : code;
    assign n_cells    = clamped[10:6];
    assign bin_next   = sub_lsb ? {clamped[5:1], 1'b0} : clamped[5:0];
    assign red_next   = sub_lsb & clamped[0];
    // n_cells tops out at 17, which would overflow the 17-bit shift
    assign fixed_mask = (n_cells >= 5'd17) ? '1 : ((17'd1 << n_cells) - 17'd1);

`ifdef DAC_DWA_EN
    logic [4:0]  ptr;
    logic [4:0]  ptr_next;
    logic [5:0]  ptr_sum;
    logic [33:0] rot;

    // Rotate the n-cell run to start at ptr, folding the overflow back onto cell 0
    always_comb begin
        rot        = {17'b0, fixed_mask} << ptr;
        therm_next = rot[16:0] | rot[33:17];
        ptr_sum    = {1'b0, ptr} + {1'b0, n_cells};
        ptr_next   = ptr;
        if (n_cells != 5'd0 && n_cells < 5'd17) begin
            if (ptr_sum >= 6'd17)
                ptr_next = 5'(ptr_sum - 6'd17);
            else
                ptr_next = ptr_sum[4:0];
        end
    end
`else
    assign therm_next = fixed_mask;
`endif

    // Enables are cleared on the way into SHUTDOWN so they drop a cycle before pdb
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            pdb        <= 1'b0;
            therm_en   <= '0;
            bin_en     <= '0;
            bin_red_en <= 1'b0;
            atb_ena    <= 2'b00;
            active     <= 1'b0;
            sat        <= 1'b0;
`ifdef DAC_DWA_EN
            ptr        <= '0;
`endif
        end else begin
            sat <= 1'b0;
            case (state)
                ST_OFF: begin
                    pdb     <= 1'b0;
                    active  <= 1'b0;
                    atb_ena <= 2'b00;
                    if (en) begin
                        state      <= ST_SETTLE;
                        pdb        <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        atb_ena    <= atb_sel;
                    end
                end
                ST_SETTLE: begin
                    if (!en) begin
                        state   <= ST_SHUTDOWN;
                        atb_ena <= 2'b00;
                    end else begin
                        atb_ena <= atb_sel;
                        if (settle_cnt == 16'd0) begin
                            state  <= ST_ACTIVE;
                            active <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - 16'd1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!en) begin
                        state      <= ST_SHUTDOWN;
                        active     <= 1'b0;
                        therm_en   <= '0;
                        bin_en     <= '0;
                        bin_red_en <= 1'b0;
                        atb_ena    <= 2'b00;
                    end else begin
                        atb_ena <= atb_sel;
                        if (code_valid) begin
                            therm_en   <= therm_next;
                            bin_en     <= bin_next;
                            bin_red_en <= red_next;
                            sat        <= over;
`ifdef DAC_DWA_EN
                            ptr        <= ptr_next;
`endif
                        end
                    end
                end
                ST_SHUTDOWN: begin
                    state      <= ST_OFF;
                    pdb        <= 1'b0;
                    active     <= 1'b0;
                    therm_en   <= '0;
                    bin_en     <= '0;
                    bin_red_en <= 1'b0;
                    atb_ena    <= 2'b00;
`ifdef DAC_DWA_EN
                    ptr        <= '0;
`endif
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_segment_decoder.sv
// Directed bench for dac_segment_decoder: power sequencing, code split tables and reset corners.
// Expected thermometer patterns follow DAC_DWA_EN when the bench is built with that macro.
module tb_dac_segment_decoder;

    logic        clk = 1'b0;
    logic        rstb;
    logic        en;
    logic [10:0] code;
    logic        code_valid;
    logic        code_ready;
    logic        sub_lsb;
    logic [1:0]  atb_sel;
    logic        pdb;
    logic [16:0] therm_en;
    logic [5:0]  bin_en;
    logic        bin_red_en;
    logic [1:0]  atb_ena;
    logic        active;
    logic        sat;

    int vec_count  = 0;
    int miscompares = 0;

    typedef struct {
        logic [10:0] code;
        logic        sub;
        logic [1:0]  atb;
        logic [16:0] therm;
        logic [5:0]  bin;
        logic        red;
        logic        sat;
    } vec_t;

    vec_t vecs[$];

    dac_segment_decoder #(.SETTLE_CYC(16)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .en         (en),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .sub_lsb    (sub_lsb),
        .atb_sel    (atb_sel),
        .pdb        (pdb),
        .therm_en   (therm_en),
        .bin_en     (bin_en),
        .bin_red_en (bin_red_en),
        .atb_ena    (atb_ena),
        .active     (active),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " pdb"}, 32'(pdb), 32'd0);
        check_output({tag, " therm_en"}, 32'(therm_en), 32'd0);
        check_output({tag, " bin_en"}, 32'(bin_en), 32'd0);
        check_output({tag, " bin_red_en"}, 32'(bin_red_en), 32'd0);
        check_output({tag, " atb_ena"}, 32'(atb_ena), 32'd0);
        check_output({tag, " active"}, 32'(active), 32'd0);
        check_output({tag, " sat"}, 32'(sat), 32'd0);
        check_output({tag, " code_ready"}, 32'(code_ready), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        code       = v.code;
        sub_lsb    = v.sub;
        atb_sel    = v.atb;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        check_output({tag, " therm_en"}, 32'(therm_en), 32'(v.therm));
        check_output({tag, " bin_en"}, 32'(bin_en), 32'(v.bin));
        check_output({tag, " bin_red_en"}, 32'(bin_red_en), 32'(v.red));
        check_output({tag, " sat"}, 32'(sat), 32'(v.sat));
        check_output({tag, " atb_ena"}, 32'(atb_ena), 32'(v.atb));
    endtask

    // en already high and reset released: 17 edges until ACTIVE
    task automatic power_up(input string tag);
        repeat (16) tick();
        check_output({tag, " code_ready before settle done"}, 32'(code_ready), 32'd0);
        tick();
        check_output({tag, " code_ready after settle"}, 32'(code_ready), 32'd1);
        check_output({tag, " active after settle"}, 32'(active), 32'd1);
    endtask

    vec_t v640;
    vec_t v1000;

    initial begin
`ifdef DAC_DWA_EN
        vecs.push_back('{11'd640,  1'b0, 2'd0, 17'h003FF, 6'h00, 1'b0, 1'b0});
        vecs.push_back('{11'd640,  1'b0, 2'd1, 17'h1FC07, 6'h00, 1'b0, 1'b0});
        vecs.push_back('{11'd640,  1'b0, 2'd2, 17'h01FF8, 6'h00, 1'b0, 1'b0});
        vecs.push_back('{11'd1151, 1'b0, 2'd3, 17'h1FFFF, 6'h3F, 1'b0, 1'b0});
        vecs.push_back('{11'd2047, 1'b0, 2'd0, 17'h1FFFF, 6'h3F, 1'b0, 1'b1});
        vecs.push_back('{11'd64,   1'b0, 2'd1, 17'h02000, 6'h00, 1'b0, 1'b0});
        vecs.push_back('{11'd5,    1'b1, 2'd2, 17'h00000, 6'h04, 1'b1, 1'b0});
        vecs.push_back('{11'd130,  1'b0, 2'd3, 17'h0C000, 6'h02, 1'b0, 1'b0});
        v1000 = '{11'd1000, 1'b0, 2'd1, 17'h13FFF, 6'h28, 1'b0, 1'b0};
`else
        vecs.push_back('{11'd1151, 1'b0, 2'd0, 17'h1FFFF, 6'h3F, 1'b0, 1'b0});
        vecs.push_back('{11'd2047, 1'b0, 2'd1, 17'h1FFFF, 6'h3F, 1'b0, 1'b1});
        vecs.push_back('{11'd64,   1'b0, 2'd2, 17'h00001, 6'h00, 1'b0, 1'b0});
        vecs.push_back('{11'd0,    1'b0, 2'd3, 17'h00000, 6'h00, 1'b0, 1'b0});
        vecs.push_back('{11'd5,    1'b1, 2'd0, 17'h00000, 6'h04, 1'b1, 1'b0});
        vecs.push_back('{11'd1151, 1'b1, 2'd1, 17'h1FFFF, 6'h3E, 1'b1, 1'b0});
        vecs.push_back('{11'd130,  1'b0, 2'd3, 17'h00003, 6'h02, 1'b0, 1'b0});
        v1000 = '{11'd1000, 1'b0, 2'd1, 17'h07FFF, 6'h28, 1'b0, 1'b0};
`endif
        v640 = '{11'd640, 1'b0, 2'd2, 17'h003FF, 6'h00, 1'b0, 1'b0};

        rstb       = 1'b0;
        en         = 1'b0;
        code       = '0;
        code_valid = 1'b0;
        sub_lsb    = 1'b0;
        atb_sel    = 2'b10;
        #12;
        check_all_zero("reset");
        tick();
        rstb = 1'b1;

        en = 1'b1;
        tick();
        check_output("pdb after en edge", 32'(pdb), 32'd1);
        check_output("code_ready at settle start", 32'(code_ready), 32'd0);
        repeat (15) tick();
        check_output("code_ready through edge 16", 32'(code_ready), 32'd0);
        check_output("active during settle", 32'(active), 32'd0);
        tick();
        check_output("code_ready from edge 17", 32'(code_ready), 32'd1);
        check_output("active from edge 17", 32'(active), 32'd1);
        check_output("atb_ena in active", 32'(atb_ena), 32'd2);

        for (int i = 0; i < vecs.size(); i++)
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));

        code = 11'd300;
        tick();
        check_output("hold therm_en", 32'(therm_en), 32'(vecs[vecs.size()-1].therm));
        check_output("hold bin_en", 32'(bin_en), 32'(vecs[vecs.size()-1].bin));
        check_output("hold sat", 32'(sat), 32'd0);

        apply_stimulus(v1000, "pre-shutdown");
        code       = 11'd1000;
        code_valid = 1'b1;
        en         = 1'b0;
        #1;
        check_output("code_ready with en low", 32'(code_ready), 32'd0);
        tick();
        code_valid = 1'b0;
        check_output("shutdown therm_en", 32'(therm_en), 32'd0);
        check_output("shutdown bin_en", 32'(bin_en), 32'd0);
        check_output("shutdown active", 32'(active), 32'd0);
        check_output("shutdown pdb still high", 32'(pdb), 32'd1);
        check_output("shutdown atb_ena", 32'(atb_ena), 32'd0);
        en = 1'b1;
        tick();
        check_output("pdb low after shutdown", 32'(pdb), 32'd0);
        check_output("atb_ena in off", 32'(atb_ena), 32'd0);
        tick();
        check_output("pdb restart from off", 32'(pdb), 32'd1);

        repeat (3) tick();
        rstb = 1'b0;
        #1;
        check_all_zero("reset mid-settle");
        tick();
        rstb = 1'b1;
        power_up("after settle reset");
        apply_stimulus(v640, "first 640 after reset");
`ifdef DAC_DWA_EN
        v640.therm = 17'h1FC07;
`endif
        apply_stimulus(v640, "second 640");

        rstb = 1'b0;
        #1;
        check_all_zero("reset pulse in active");
        tick();
        rstb = 1'b1;
        power_up("after active reset");
        v640.therm = 17'h003FF;
        apply_stimulus(v640, "640 after pointer reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
